// File: rtl/fila_ctrl.sv
// rtl/fila_ctrl.sv - push-button command stage feeding the fila byte queue
//
// Turns two raw push-buttons and an 8-bit switch bank into clean one-cycle
// enqueue/dequeue strobes plus the byte to enqueue. Each button is
// synchronised, debounced on press and on release, and edge-qualified, so
// one physical press yields exactly one queue operation.
//
// Optional feature macro: FILA_CTRL_GUARD_EN
//   defined   : refuse enqueue when len_in >= 8 and dequeue when len_in == 0,
//               pulsing reject_out instead of the operation strobe.
//   undefined : strobes always issued, reject_out stays 0, len_in unused.
//
// Ports:
//   clk_10KHz   in   1  system clock, all state on rising edge
//   reset       in   1  asynchronous active-high reset
//   sw_data_in  in   8  switch value to enqueue
//   btn_enq     in   1  raw enqueue button (asynchronous)
//   btn_deq     in   1  raw dequeue button (asynchronous)
//   len_in      in   4  queue occupancy 0..8 (guard feedback)
//   data_out    out  8  byte presented to the queue data input
//   enqueue_out out  1  one-cycle enqueue strobe
//   dequeue_out out  1  one-cycle dequeue strobe
//   reject_out  out  1  one-cycle strobe for a press refused by the guard

module fila_ctrl #(
  parameter int DEBOUNCE_CYCLES = 200
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic [7:0] sw_data_in,
  input  logic       btn_enq,
  input  logic       btn_deq,
  input  logic [3:0] len_in,
  output logic [7:0] data_out,
  output logic       enqueue_out,
  output logic       dequeue_out,
  output logic       reject_out
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, FIRE, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_enq_q, sel_enq_d;
  logic [1:0]    enq_sync_q, enq_sync_d;
  logic [1:0]    deq_sync_q, deq_sync_d;
  logic [7:0]    data_q, data_d;
  logic          enq_q, enq_d;
  logic          deq_q, deq_d;
  logic          rej_q, rej_d;

  logic          btn_enq_s, btn_deq_s, sel_btn_s, blocked;

  assign btn_enq_s = enq_sync_q[1];
  assign btn_deq_s = deq_sync_q[1];
  // Only the button that started the debounce decides whether it survives.
  assign sel_btn_s = sel_enq_q ? btn_enq_s : btn_deq_s;

`ifdef FILA_CTRL_GUARD_EN
  assign blocked = sel_enq_q ? (len_in >= 4'd8) : (len_in == 4'd0);
`else
  logic unused_len;
  assign unused_len = ^len_in;
  assign blocked    = 1'b0;
`endif

  always_comb begin
    enq_sync_d = {enq_sync_q[0], btn_enq};
    deq_sync_d = {deq_sync_q[0], btn_deq};
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_enq_d  = sel_enq_q;
    data_d     = data_q;
    enq_d      = 1'b0;
    deq_d      = 1'b0;
    rej_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_enq_s) begin
          sel_enq_d = 1'b1;
          state_d   = DEBOUNCE;
          cnt_d     = '0;
        end else if (btn_deq_s) begin
          sel_enq_d = 1'b0;
          state_d   = DEBOUNCE;
          cnt_d     = '0;
        end
      end
      DEBOUNCE: begin
        if (!sel_btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Strobes are registered, so they are decided on the edge into FIRE.
          state_d = FIRE;
          cnt_d   = '0;
          if (blocked) begin
            rej_d = 1'b1;
          end else if (sel_enq_q) begin
            enq_d  = 1'b1;
            data_d = sw_data_in;
          end else begin
            deq_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        // Any button activity restarts the release window.
        if (btn_enq_s || btn_deq_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_enq_q  <= 1'b0;
      enq_sync_q <= 2'b00;
      deq_sync_q <= 2'b00;
      data_q     <= 8'h00;
      enq_q      <= 1'b0;
      deq_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_enq_q  <= sel_enq_d;
      enq_sync_q <= enq_sync_d;
      deq_sync_q <= deq_sync_d;
      data_q     <= data_d;
      enq_q      <= enq_d;
      deq_q      <= deq_d;
      rej_q      <= rej_d;
    end
  end

  assign data_out    = data_q;
  assign enqueue_out = enq_q;
  assign dequeue_out = deq_q;
  assign reject_out  = rej_q;

endmodule

// File: tb/tb_fila_ctrl.sv
// tb/tb_fila_ctrl.sv - self-checking bench for fila_ctrl
module tb_fila_ctrl;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;
`ifdef FILA_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk_10KHz = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] sw_data_in = 8'h00;
  logic       btn_enq = 1'b0;
  logic       btn_deq = 1'b0;
  logic [3:0] len_in = 4'd0;
  logic [7:0] data_out;
  logic       enqueue_out, dequeue_out, reject_out;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model_data = 8'h00;

  typedef struct {
    bit         e;
    bit         d;
    bit         r;
    logic [7:0] data;
    int         at;
  } exp_t;

  typedef struct {
    string      name;
    bit         e;
    bit         d;
    logic [7:0] sw;
    logic [3:0] len;
    int         hold;
    bit         xe;
    bit         xd;
    bit         xr;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_x;
  vec_t tbl[9];
  vec_t fresh;

  fila_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .sw_data_in (sw_data_in),
    .btn_enq    (btn_enq),
    .btn_deq    (btn_deq),
    .len_in     (len_in),
    .data_out   (data_out),
    .enqueue_out(enqueue_out),
    .dequeue_out(dequeue_out),
    .reject_out (reject_out)
  );

  always #5 clk_10KHz = ~clk_10KHz;
  always @(posedge clk_10KHz) cyc <= cyc + 1;

  // Scoreboard consumer: every strobe must match the head of the queue in
  // kind and exact cycle; data_out must track the model at all other times.
  always @(negedge clk_10KHz) begin
    if (!reset) begin
      if (enqueue_out || dequeue_out || reject_out) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe: got enq=%0b deq=%0b rej=%0b at cycle %0d, expected no strobe",
                   enqueue_out, dequeue_out, reject_out, cyc);
        end else begin
          mon_x = sbq.pop_front();
          if ({enqueue_out, dequeue_out, reject_out} !== {mon_x.e, mon_x.d, mon_x.r} || cyc != mon_x.at) begin
            n_bad++;
            $display("FAIL strobe: got enq/deq/rej=%b%b%b at cycle %0d, expected %b%b%b at cycle %0d",
                     enqueue_out, dequeue_out, reject_out, cyc, mon_x.e, mon_x.d, mon_x.r, mon_x.at);
          end
          if (mon_x.e) model_data = mon_x.data;
          n_cmp++;
          if (data_out !== model_data) begin
            n_bad++;
            $display("FAIL data_at_strobe: got %02h expected %02h at cycle %0d", data_out, model_data, cyc);
          end
        end
      end else begin
        n_cmp++;
        if (data_out !== model_data) begin
          n_bad++;
          $display("FAIL data_hold: got %02h expected %02h at cycle %0d", data_out, model_data, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_10KHz);
      #2;
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({data_out, enqueue_out, dequeue_out, reject_out} !== 11'd0) begin
      n_bad++;
      $display("FAIL %s: got data=%02h enq=%0b deq=%0b rej=%0b, expected all zero",
               name, data_out, enqueue_out, dequeue_out, reject_out);
    end
  endtask

  task automatic drain(input string name);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL missing_strobe %s: got %0d pending, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic push(input bit e, input bit d, input bit r, input logic [7:0] data, input int at);
    exp_t x;
    x.e = e; x.d = d; x.r = r; x.data = data; x.at = at;
    sbq.push_back(x);
  endtask

  task automatic press(input vec_t v);
    int n0;
    step(1);
    sw_data_in = v.sw;
    len_in     = v.len;
    btn_enq    = v.e;
    btn_deq    = v.d;
    n0         = cyc;
    if (v.xe || v.xd || v.xr) push(v.xe, v.xd, v.xr, v.sw, n0 + LAT);
    step(v.hold);
    btn_enq = 1'b0;
    btn_deq = 1'b0;
    step(20);
    drain(v.name);
  endtask

  initial begin
    int n0;
    int r0;

    tbl[0] = '{"enq_a5",        1, 0, 8'hA5, 4'd0, 20, 1,      0,      0};
    tbl[1] = '{"both_enq_wins", 1, 1, 8'h3C, 4'd1, 10, 1,      0,      0};
    tbl[2] = '{"deq_after",     0, 1, 8'hFF, 4'd2, 10, 0,      1,      0};
    tbl[3] = '{"enq_full",      1, 0, 8'h5A, 4'd8, 10, !GUARD, 0,      GUARD};
    tbl[4] = '{"deq_empty",     0, 1, 8'h00, 4'd0, 10, 0,      !GUARD, GUARD};
    tbl[5] = '{"enq_len7",      1, 0, 8'h81, 4'd7, 10, 1,      0,      0};
    tbl[6] = '{"deq_len8",      0, 1, 8'h11, 4'd8, 10, 0,      1,      0};
    tbl[7] = '{"hold_short",    1, 0, 8'hE7, 4'd3, 4,  0,      0,      0};
    tbl[8] = '{"hold_min",      1, 0, 8'hC3, 4'd3, 5,  1,      0,      0};
    fresh  = '{"fresh_press",   1, 0, 8'h24, 4'd3, 10, 1,      0,      0};

    repeat (3) @(posedge clk_10KHz);
    #2;
    check_zero("reset_state");
    reset = 1'b0;
    step(4);

    // Bounce during DEBOUNCE: two short highs, no strobe, data stays 0x00.
    sw_data_in = 8'h99;
    btn_enq = 1'b1; step(2);
    btn_enq = 1'b0; step(1);
    btn_enq = 1'b1; step(2);
    btn_enq = 1'b0; step(20);
    drain("bounce");
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_bad++;
      $display("FAIL bounce_data: got %02h expected 00", data_out);
    end

    for (int i = 0; i < 9; i++) press(tbl[i]);

    // Reset two cycles into DEBOUNCE with the button still held.
    step(1);
    sw_data_in = 8'h77;
    len_in     = 4'd0;
    btn_enq    = 1'b1;
    step(5);
    reset      = 1'b1;
    model_data = 8'h00;
    sbq.delete();
    #1;
    check_zero("reset_immediate");
    step(2);
    check_zero("reset_hold");
    reset = 1'b0;
    r0    = cyc;
    push(1, 0, 0, 8'h77, r0 + LAT);
    step(20);
    btn_enq = 1'b0;
    step(20);
    drain("held_across_reset");

    // Release bounce: 3 low cycles are one short of leaving RELEASE.
    step(1);
    sw_data_in = 8'h42;
    len_in     = 4'd3;
    btn_enq    = 1'b1;
    n0         = cyc;
    push(1, 0, 0, 8'h42, n0 + LAT);
    step(10);
    btn_enq = 1'b0; step(3);
    btn_enq = 1'b1; step(5);
    btn_enq = 1'b0; step(20);
    drain("release_bounce");
    press(fresh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
